// File: rtl/decode_stage_if.sv
// Handshake and bus bundle between fetch, the decode stage and the ALU/register file.
// master = the surrounding pipeline (drives instructions, consumes bundles, retires writes);
// slave  = the decode stage itself.
interface decode_stage_if #(
  parameter int RA_W  = 3,
  parameter int PC_W  = 7,
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
);
  localparam int INSTR_W = 4 + 3 * RA_W;

  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [INSTR_W-1:0]   instruction_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [RA_W-1:0]      alu_op_a_addr_o;
  logic [RA_W-1:0]      alu_op_b_addr_o;
  logic [2:0]           alu_opcode_o;
  logic                 rd_en_o;
  logic                 wr_en_o;
  logic [RA_W-1:0]      wr_addr_o;
  logic                 branch_en_o;
  logic [PC_W-1:0]      branch_addr_o;
  logic [IMM_W-1:0]     immediate_o;
  logic                 immediate_en_o;
  logic                 illegal_o;
  logic                 wb_valid_i;
  logic [RA_W-1:0]      wb_addr_i;
  logic [2**RA_W-1:0]   busy_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  modport master (
    output flush_i, in_valid_i, instruction_i, out_ready_i, wb_valid_i, wb_addr_i,
    input  in_ready_o, out_valid_o, alu_op_a_addr_o, alu_op_b_addr_o, alu_opcode_o,
           rd_en_o, wr_en_o, wr_addr_o, branch_en_o, branch_addr_o, immediate_o,
           immediate_en_o, illegal_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, instruction_i, out_ready_i, wb_valid_i, wb_addr_i,
    output in_ready_o, out_valid_o, alu_op_a_addr_o, alu_op_b_addr_o, alu_opcode_o,
           rd_en_o, wr_en_o, wr_addr_o, branch_en_o, branch_addr_o, immediate_o,
           immediate_en_o, illegal_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready on both sides, a per-register
// scoreboard that stalls RAW/WAW hazards, a flush input and a saturating stall counter.
module decode_stage #(
  parameter int RA_W       = 3,
  parameter int PC_W       = 7,
  parameter int IMM_W      = 8,
  parameter int IMM_SIGNED = 0,
  parameter int CNT_W      = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  decode_stage_if.slave  bus
);
  localparam int INSTR_W = 4 + 3 * RA_W;
  localparam int NREG    = 2 ** RA_W;

  typedef struct packed {
    logic [RA_W-1:0]  op_a;
    logic [RA_W-1:0]  op_b;
    logic [2:0]       opcode;
    logic             rd_en;
    logic             wr_en;
    logic [RA_W-1:0]  wr_addr;
    logic             br_en;
    logic [PC_W-1:0]  br_addr;
    logic [IMM_W-1:0] imm;
    logic             imm_en;
    logic             illegal;
  } bundle_t;

  // {rA,rB} widened to the immediate width, sign- or zero-extended
  function automatic logic [IMM_W-1:0] ext_imm(input logic [2*RA_W-1:0] f);
    logic signed [2*RA_W-1:0] fs;
    fs = f;
    if (IMM_SIGNED != 0) ext_imm = IMM_W'(fs);
    else                 ext_imm = IMM_W'(f);
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [INSTR_W-1:0] instr;
  logic               cls;
  logic [2:0]         opc;
  logic [RA_W-1:0]    ra, rb, rd;
  logic               is_ldi, is_ill, is_br;
  bundle_t            dec;
  logic               hazard, ready, issue;

  bundle_t            bundle_d, bundle_q;
  logic               out_valid_d, out_valid_q;
  logic [NREG-1:0]    busy_d, busy_q;
  logic [CNT_W-1:0]   stall_d, stall_q;

  assign instr = bus.instruction_i;
  assign cls   = instr[INSTR_W-1];
  assign opc   = instr[INSTR_W-2 -: 3];
  assign ra    = instr[3*RA_W-1 -: RA_W];
  assign rb    = instr[2*RA_W-1 -: RA_W];
  assign rd    = instr[RA_W-1:0];

  // Field decode of the incoming instruction; illegal opcodes carry no enables
  always_comb begin
    is_ldi      = cls & (opc == 3'b010);
    is_ill      = cls & ((opc == 3'b011) | opc[2]);
    is_br       = cls & (opc[2:1] == 2'b00);
    dec         = '0;
    dec.op_a    = ra;
    dec.op_b    = rb;
    dec.opcode  = opc;
    dec.wr_addr = rd;
    dec.br_addr = instr[PC_W-1:0];
    dec.imm     = ext_imm({ra, rb});
    dec.illegal = is_ill;
    dec.rd_en   = ~cls;
    dec.wr_en   = ~cls | is_ldi;
    dec.br_en   = is_br;
    dec.imm_en  = is_ldi;
  end

  // Hazards look only at the registered scoreboard: a retiring write frees its
  // register one cycle after the writeback pulse, never in the same cycle.
  assign hazard = bus.in_valid_i &
                  ((dec.rd_en & (busy_q[ra] | busy_q[rb])) | (dec.wr_en & busy_q[rd]));
  assign ready  = (~out_valid_q | bus.out_ready_i) & ~hazard & ~bus.flush_i;
  assign issue  = bus.in_valid_i & ready;

  // Next-state for output bundle, scoreboard and stall counter
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (bus.flush_i) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // Clear first so that a same-cycle issue to the same register wins
    busy_d = busy_q;
    if (bus.wb_valid_i) busy_d[bus.wb_addr_i] = 1'b0;
    if (issue && dec.wr_en) busy_d[rd] = 1'b1;

    stall_d = (hazard && !bus.flush_i) ? sat_inc(stall_q) : stall_q;
  end

  // Stage registers; reset returns everything to zero and forgets outstanding writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= '0;
      stall_q     <= '0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready_o      = ready;
  assign bus.out_valid_o     = out_valid_q;
  assign bus.alu_op_a_addr_o = bundle_q.op_a;
  assign bus.alu_op_b_addr_o = bundle_q.op_b;
  assign bus.alu_opcode_o    = bundle_q.opcode;
  assign bus.rd_en_o         = bundle_q.rd_en;
  assign bus.wr_en_o         = bundle_q.wr_en;
  assign bus.wr_addr_o       = bundle_q.wr_addr;
  assign bus.branch_en_o     = bundle_q.br_en;
  assign bus.branch_addr_o   = bundle_q.br_addr;
  assign bus.immediate_o     = bundle_q.imm;
  assign bus.immediate_en_o  = bundle_q.imm_en;
  assign bus.illegal_o       = bundle_q.illegal;
  assign bus.busy_o          = busy_q;
  assign bus.stall_cnt_o     = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, a behavioural model checked every cycle,
// and literal expectations at the key points.
module tb_decode_stage;
  localparam int RA_W  = 3;
  localparam int PC_W  = 7;
  localparam int IMM_W = 8;
  localparam int CNT_W = 16;
  localparam int NREG  = 1 << RA_W;
  localparam longint CMAX = (longint'(1) << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.RA_W(RA_W), .PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();
  decode_stage_if #(.RA_W(RA_W), .PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus_s ();

  decode_stage #(.RA_W(RA_W), .PC_W(PC_W), .IMM_W(IMM_W), .IMM_SIGNED(0), .CNT_W(CNT_W))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  decode_stage #(.RA_W(RA_W), .PC_W(PC_W), .IMM_W(IMM_W), .IMM_SIGNED(1), .CNT_W(CNT_W))
    dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s.slave));

  assign bus_s.flush_i       = bus.flush_i;
  assign bus_s.in_valid_i    = bus.in_valid_i;
  assign bus_s.instruction_i = bus.instruction_i;
  assign bus_s.out_ready_i   = bus.out_ready_i;
  assign bus_s.wb_valid_i    = bus.wb_valid_i;
  assign bus_s.wb_addr_i     = bus.wb_addr_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int a, b, op, wa, rd_en, wr_en, br_en, baddr, imm, imm_en, ill;
  } exp_t;

  function automatic exp_t decode_m(input int ins, input bit sgn);
    exp_t e;
    int r, cls, op, ra, rb, rd, raw;
    r   = NREG;
    rd  = ins % r;
    rb  = (ins / r) % r;
    ra  = (ins / (r * r)) % r;
    op  = (ins / (r * r * r)) % 8;
    cls = ins / (r * r * r * 8);
    e.a = ra; e.b = rb; e.op = op; e.wa = rd;
    e.ill    = (cls == 1 && op >= 3) ? 1 : 0;
    e.rd_en  = (cls == 0) ? 1 : 0;
    e.imm_en = (cls == 1 && op == 2) ? 1 : 0;
    e.wr_en  = (cls == 0 || e.imm_en == 1) ? 1 : 0;
    e.br_en  = (cls == 1 && op < 2) ? 1 : 0;
    if (e.ill != 0) begin
      e.rd_en = 0; e.wr_en = 0; e.br_en = 0; e.imm_en = 0;
    end
    e.baddr = ins % (1 << PC_W);
    raw = ra * r + rb;
    if (sgn && raw >= (r * r) / 2) raw = raw - r * r;
    e.imm = (raw + (1 << IMM_W)) % (1 << IMM_W);
    return e;
  endfunction

  bit     m_live = 1'b0;
  bit     m_valid;
  exp_t   m_b;
  bit     m_busy [NREG];
  longint m_cnt;

  function automatic bit m_hazard();
    exp_t e;
    if (bus.in_valid_i !== 1'b1) return 1'b0;
    e = decode_m(int'(bus.instruction_i), 1'b0);
    return (e.rd_en != 0 && (m_busy[e.a] || m_busy[e.b])) || (e.wr_en != 0 && m_busy[e.wa]);
  endfunction

  function automatic bit m_ready();
    return (!m_valid || bus.out_ready_i === 1'b1) && !m_hazard() && bus.flush_i !== 1'b1;
  endfunction

  function automatic int busy_vec();
    int v = 0;
    for (int i = 0; i < NREG; i++) if (m_busy[i]) v = v | (1 << i);
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit   hz, iss;
    exp_t e;
    if (rst) begin
      m_live  = 1'b1;
      m_valid = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (m_live) begin
      e   = decode_m(int'(bus.instruction_i), 1'b0);
      hz  = m_hazard();
      iss = bus.in_valid_i && m_ready();
      if (hz && !bus.flush_i && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (bus.wb_valid_i) m_busy[bus.wb_addr_i] = 1'b0;
      if (iss && e.wr_en != 0) m_busy[e.wa] = 1'b1;
      if (bus.flush_i)          m_valid = 1'b0;
      else if (iss)             begin m_valid = 1'b1; m_b = e; end
      else if (bus.out_ready_i) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_in_ready",  bus.in_ready_o,  m_ready());
      chk("m_out_valid", bus.out_valid_o, m_valid);
      chk("m_busy",      bus.busy_o,      busy_vec());
      chk("m_stall_cnt", bus.stall_cnt_o, m_cnt);
      if (m_valid) begin
        chk("m_op_a",    bus.alu_op_a_addr_o, m_b.a);
        chk("m_op_b",    bus.alu_op_b_addr_o, m_b.b);
        chk("m_opcode",  bus.alu_opcode_o,    m_b.op);
        chk("m_rd_en",   bus.rd_en_o,         m_b.rd_en);
        chk("m_wr_en",   bus.wr_en_o,         m_b.wr_en);
        chk("m_wr_addr", bus.wr_addr_o,       m_b.wa);
        chk("m_br_en",   bus.branch_en_o,     m_b.br_en);
        chk("m_br_addr", bus.branch_addr_o,   m_b.baddr);
        chk("m_imm",     bus.immediate_o,     m_b.imm);
        chk("m_imm_en",  bus.immediate_en_o,  m_b.imm_en);
        chk("m_illegal", bus.illegal_o,       m_b.ill);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.flush_i       = 1'b0;
    bus.in_valid_i    = 1'b0;
    bus.instruction_i = '0;
    bus.out_ready_i   = 1'b1;
    bus.wb_valid_i    = 1'b0;
    bus.wb_addr_i     = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_busy",      bus.busy_o,      0);
    chk("rst_stall",     bus.stall_cnt_o, 0);
    chk("rst_opcode",    bus.alu_opcode_o, 0);
    chk("rst_imm",       bus.immediate_o, 0);
    rst = 1'b0;

    // ALU op r1,r2 -> r5
    bus.in_valid_i = 1'b1; bus.instruction_i = 13'h0655;
    tick();
    chk("t1_out_valid", bus.out_valid_o, 1);
    chk("t1_opcode",    bus.alu_opcode_o, 3);
    chk("t1_a",         bus.alu_op_a_addr_o, 1);
    chk("t1_b",         bus.alu_op_b_addr_o, 2);
    chk("t1_wr_addr",   bus.wr_addr_o, 5);
    chk("t1_rd_en",     bus.rd_en_o, 1);
    chk("t1_wr_en",     bus.wr_en_o, 1);
    chk("t1_busy",      bus.busy_o, 8'h20);

    // RAW on r5: stall until the cycle after writeback
    bus.instruction_i = 13'h0146;
    #1 chk("t2_ready_stalled", bus.in_ready_o, 0);
    tick(); tick(); tick();
    chk("t2_stall3", bus.stall_cnt_o, 3);
    chk("t2_drained", bus.out_valid_o, 0);
    bus.wb_valid_i = 1'b1; bus.wb_addr_i = 3'd5;
    tick();
    bus.wb_valid_i = 1'b0;
    #1 chk("t2_ready_after_wb", bus.in_ready_o, 1);
    chk("t2_stall4", bus.stall_cnt_o, 4);
    tick();
    chk("t2_issued",  bus.out_valid_o, 1);
    chk("t2_wr_addr", bus.wr_addr_o, 6);
    chk("t2_busy",    bus.busy_o, 8'h40);

    // LDI 0x2A -> r3
    bus.instruction_i = 13'h1553;
    tick();
    chk("t3_imm",     bus.immediate_o, 8'h2A);
    chk("t3_imm_s",   bus_s.immediate_o, 8'hEA);
    chk("t3_imm_en",  bus.immediate_en_o, 1);
    chk("t3_wr_en",   bus.wr_en_o, 1);
    chk("t3_rd_en",   bus.rd_en_o, 0);
    chk("t3_busy",    bus.busy_o, 8'h48);

    // branch, then illegal
    bus.instruction_i = 13'h1045;
    tick();
    chk("t4_br_en",   bus.branch_en_o, 1);
    chk("t4_br_addr", bus.branch_addr_o, 7'h45);
    chk("t4_wr_en",   bus.wr_en_o, 0);
    chk("t4_busy",    bus.busy_o, 8'h48);
    bus.instruction_i = 13'h1E00;
    tick();
    chk("t4_illegal", bus.illegal_o, 1);
    chk("t4_ill_en",  {bus.rd_en_o, bus.wr_en_o, bus.branch_en_o, bus.immediate_en_o}, 0);

    // hold under back-pressure, then flush
    bus.instruction_i = 13'h0655;
    tick();
    chk("t5_busy_set", bus.busy_o, 8'h68);
    bus.out_ready_i = 1'b0; bus.instruction_i = 13'h1045;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_valid",  bus.out_valid_o, 1);
      chk("t5_hold_waddr",  bus.wr_addr_o, 5);
      chk("t5_hold_opcode", bus.alu_opcode_o, 3);
      chk("t5_hold_br",     bus.branch_en_o, 0);
      chk("t5_hold_ready",  bus.in_ready_o, 0);
    end
    bus.flush_i = 1'b1; bus.instruction_i = 13'h0146;
    #1 chk("t5_flush_ready", bus.in_ready_o, 0);
    tick();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    chk("t5_flush_valid", bus.out_valid_o, 0);
    chk("t5_flush_busy",  bus.busy_o, 8'h68);
    chk("t5_flush_stall", bus.stall_cnt_o, 4);

    // same-cycle issue to r2 and writeback of r2: set wins
    bus.in_valid_i = 1'b1; bus.instruction_i = 13'h0002;
    bus.wb_valid_i = 1'b1; bus.wb_addr_i = 3'd2;
    tick();
    chk("t6_set_wins", bus.busy_o, 8'h6C);
    bus.in_valid_i = 1'b0; bus.wb_addr_i = 3'd0;
    tick();
    bus.wb_valid_i = 1'b0;
    chk("t6_wb_noop", bus.busy_o, 8'h6C);

    // sustained hazard on r2 to saturate the stall counter
    bus.in_valid_i = 1'b1; bus.instruction_i = 13'h0080;
    repeat (65540) @(posedge clk);
    #1;
    chk("t6_saturated", bus.stall_cnt_o, 16'hFFFF);
    chk("t6_sat_ready", bus.in_ready_o, 0);

    // reset mid-operation forgets in-flight writes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_busy",  bus.busy_o, 0);
    chk("t7_stall", bus.stall_cnt_o, 0);
    chk("t7_valid", bus.out_valid_o, 0);
    bus.instruction_i = 13'h0655;
    #1 chk("t7_ready", bus.in_ready_o, 1);
    tick();
    bus.in_valid_i = 1'b0;
    chk("t7_reissue_busy", bus.busy_o, 8'h20);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
